probe_buffer_drain: RTL and testbench
=====================================

# probe_buffer_drain

Consumer end of the probe-buffer write channel. Accepts 64-bit probe words from the core-side `wen`/`write` port, buffers them in an on-chip FIFO and drains them to the harness over a valid/ready stream. Gives hardware-side ordering, overflow accounting and an end-of-test flush sequence. Sits in the test harness between each probe source and the DPI drain.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2
- DATA_W, 64, probe word width

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- write  in  DATA_W  probe word from producer
- wen  in  1  producer write strobe; one word per asserted cycle
- read  out  64  status word: {drop_count[31:0], 15'b0, flushing, level[15:0]}
- done  in  1  end-of-test request; level-sensitive, sampled each cycle
- out_valid  out  1  drain word available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  DATA_W  head word
- out_seq  out  32  sequence number of head word
- overflow  out  1  sticky; set on first dropped write
- drained  out  1  high in DONE state

## Operation
- FSM states: RUN, FLUSH, DONE.
  - RUN → FLUSH when `done`=1.
  - FLUSH → DONE when the FIFO is empty and no write was accepted that cycle.
  - DONE holds until reset.
- RUN: `wen` enqueues `write` if the FIFO is not full, or if it is full and a dequeue happens in the same cycle.
  - Otherwise the word is dropped: `drop_count` increments (saturates at 0xFFFF_FFFF) and `overflow` is set.
- FLUSH and DONE: `wen` is ignored; no drop is counted.
- The write in the RUN→FLUSH transition cycle is still accepted.
- Dequeue on `out_valid && out_ready`. `out_valid` = FIFO not empty, in any state.
- Sequence numbering: each accepted write is tagged with `wr_seq`, which then increments and wraps mod 2^32. `out_seq` is the tag of the head word.
- `level` = FIFO occupancy, 0..DEPTH, zero-extended to 16 bits.
- `read` is registered and reflects state as of the previous cycle.
- `flushing` bit in `read` is 1 in FLUSH only.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_seq=0, overflow=0, drained=0, read=0
  - level=0, drop_count=0, wr_seq=0, state=RUN
- Latency: word written in cycle N is on `out_data` with `out_valid`=1 in cycle N+1 if the FIFO was empty. There is no combinational path from `write` to `out_data`.
- `out_data` and `out_seq` stay stable while `out_valid && !out_ready`.
- Simultaneous enqueue and dequeue: `level` unchanged; pointers wrap mod DEPTH.
- Full and empty are distinguished with an extra pointer MSB.
- `drained` rises the cycle after the FSM enters DONE, registered.
- Reset mid-stream: contents discarded and every output returns to its reset value on the next edge.

## Configuration
- PROBE_DRAIN_SEQ_EN
  - Defined: `wr_seq` counter and a 32-bit tag per FIFO entry; `out_seq` as above.
  - Undefined: no tag storage; `out_seq` tied to 0. All other behaviour identical.

## Structure
- Package `probe_drain_pkg`:
  - FSM state enum `drain_state_e` {RUN, FLUSH, DONE}
  - status-word field offsets and widths
  - `SEQ_W`=32 and `CNT_W`=32 constants
- Sub-module `probe_sync_fifo`:
  - Parameterized width and depth.
  - Ports: push/pop/full/empty/count and head data.
  - Instantiated once, with width DATA_W or DATA_W+32 depending on the macro.

## Test plan
- Single write 0xDEAD_BEEF_0000_0001 at cycle 5, out_ready=1 → out_valid=1 at cycle 6 with that data and out_seq=0; level back to 0 at cycle 7.
- 16 back-to-back writes with out_ready=0 → level=16. A 17th write → drop_count=1, overflow=1, FIFO contents unchanged, then drain 16 words in order with seq 0..15.
- Full FIFO, wen=1 and out_ready=1 in the same cycle → write accepted, level stays 16, no drop.
- Random wen and out_ready for 10k cycles against a scoreboard → exact data order, wr_seq wrap verified by preloading wr_seq to 0xFFFF_FFFE (macro on); drops equal scoreboard count.
- done=1 with 5 words queued and wen held high → exactly one more write accepted, then none. After 6 dequeues: DONE, and drained=1 the following cycle.
- Reset asserted with 8 words queued → next cycle out_valid=0, level=0, read=0, state RUN.

Source files
------------

// File: rtl/probe_drain_pkg.sv
// Shared types and constants for the probe-buffer drain block.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state enum, status-word field layout, counter/sequence widths,
//           and a helper that packs the status word.
package probe_drain_pkg;

  localparam int SEQ_W     = 32;  // sequence tag width
  localparam int CNT_W     = 32;  // drop counter width

  // Status word layout: {drop_count, 15'b0, flushing, level}
  localparam int STATUS_W  = 64;
  localparam int LEVEL_LSB = 0;
  localparam int LEVEL_W   = 16;
  localparam int FLUSH_BIT = 16;
  localparam int DROP_LSB  = 32;
  localparam int DROP_W    = CNT_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  function automatic logic [STATUS_W-1:0] pack_status(
    input logic [CNT_W-1:0]   drops,
    input logic               flushing,
    input logic [LEVEL_W-1:0] level
  );
    logic [STATUS_W-1:0] w;
    w                        = '0;
    w[DROP_LSB +: DROP_W]    = drops;
    w[FLUSH_BIT]             = flushing;
    w[LEVEL_LSB +: LEVEL_W]  = level;
    return w;
  endfunction

endpackage

// File: rtl/probe_sync_fifo.sv
// Single-clock FIFO with registered storage and a head-of-queue read port.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clock, reset (sync, active-high), push/push_data, pop, head,
//        full, empty, count (0..DEPTH).
module probe_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra MSB: equal low bits with differing MSBs means
  // the write side has lapped the read side exactly once, i.e. full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  // A pop frees the head slot at the same edge, so a full FIFO can still
  // take a word; it lands in the slot being vacated.
  assign do_push = push && (!full || do_pop);

  // Storage is not reset, so the head is masked while empty to keep the
  // output at zero after reset and between bursts.
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/probe_buffer_drain.sv
// Buffers probe words from a write-strobe producer and drains them over valid/ready,
// with drop accounting and an end-of-test flush. Latency: 1 cycle write-to-head.
// Backpressure: out_ready stalls the head; writes into a full FIFO are dropped and counted.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   write, wen          producer word and strobe (one word per strobe cycle)
//   done                end-of-test request, level-sensitive
//   out_valid/out_ready drain handshake; out_data/out_seq carry the head word and its tag
//   read                registered status {drop_count, 15'b0, flushing, level}
//   overflow            sticky, set on the first dropped write
//   drained             registered, high once the FSM has reached DONE
//
// Build option: define PROBE_DRAIN_SEQ_EN to tag each word with a 32-bit sequence
// number (out_seq); without it no tag storage exists and out_seq is zero.
module probe_buffer_drain
  import probe_drain_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64
`ifdef PROBE_DRAIN_SEQ_EN
  ,
  // Starting value of the sequence counter after reset; lets a harness
  // begin numbering near the wrap point.
  parameter logic [SEQ_W-1:0] SEQ_INIT = '0
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   write,
  input  logic                wen,
  output logic [STATUS_W-1:0] read,
  input  logic                done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [SEQ_W-1:0]    out_seq,
  output logic                overflow,
  output logic                drained
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

`ifdef PROBE_DRAIN_SEQ_EN
  localparam int FW = DATA_W + SEQ_W;
`else
  localparam int FW = DATA_W;
`endif

  drain_state_e      state_q;
  drain_state_e      state_d;
  logic              enq;
  logic              deq;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [FW-1:0]     fifo_in;
  logic [FW-1:0]     fifo_head;
  logic [CNT_W-1:0]  drop_count;

  // Draining is independent of the FSM: whatever is queued always leaves.
  assign out_valid = !fifo_empty;
  assign deq       = out_valid && out_ready;

  // Next state and write admission. Writes are admitted only while the
  // registered state is RUN, so the cycle in which done is first seen
  // still accepts its write.
  always_comb begin
    state_d = state_q;
    enq     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      RUN: begin
        if (wen) begin
          if (!fifo_full || deq) enq  = 1'b1;
          else                   drop = 1'b1;
        end
        if (done) state_d = FLUSH;
      end
      FLUSH: begin
        if (fifo_empty && !enq) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      drop_count <= '0;
      overflow   <= 1'b0;
      drained    <= 1'b0;
      read       <= '0;
    end else begin
      state_q <= state_d;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_ONE;
      end
      drained <= (state_q == DONE);
      // Snapshot of this cycle's registers; visible one cycle later.
      read    <= pack_status(drop_count, state_q == FLUSH, LEVEL_W'(fifo_count));
    end
  end

`ifdef PROBE_DRAIN_SEQ_EN
  logic [SEQ_W-1:0] wr_seq;
  localparam logic [SEQ_W-1:0] SEQ_ONE = 1;

  always_ff @(posedge clock) begin
    if (reset)    wr_seq <= SEQ_INIT;
    else if (enq) wr_seq <= wr_seq + SEQ_ONE;
  end

  assign fifo_in  = {wr_seq, write};
  assign out_data = fifo_head[DATA_W-1:0];
  assign out_seq  = fifo_head[DATA_W +: SEQ_W];
`else
  assign fifo_in  = write;
  assign out_data = fifo_head;
  assign out_seq  = '0;
`endif

  probe_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (enq),
    .push_data (fifo_in),
    .pop       (deq),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_probe_buffer_drain.sv
// Testbench for probe_buffer_drain: directed scenarios plus a long random run,
// compared every cycle against a queue-based behavioural model.
module tb_probe_buffer_drain;

  localparam int DEPTH = 16;
  localparam int DW    = 64;
`ifdef PROBE_DRAIN_SEQ_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [DW-1:0] write;
  logic          wen;
  logic          done;
  logic          out_ready;
  logic [63:0]   read;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [31:0]   out_seq;
  logic          overflow;
  logic          drained;

  probe_buffer_drain #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .write     (write),
    .wen       (wen),
    .read      (read),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .overflow  (overflow),
    .drained   (drained)
  );

`ifdef PROBE_DRAIN_SEQ_EN
  // Second copy whose sequence counter starts just below the wrap point.
  logic [63:0]   w_read;
  logic          w_out_valid;
  logic [DW-1:0] w_out_data;
  logic [31:0]   w_out_seq;
  logic          w_overflow;
  logic          w_drained;

  probe_buffer_drain #(.DEPTH(DEPTH), .DATA_W(DW), .SEQ_INIT(32'hFFFF_FFFE)) dut_wrap (
    .clock     (clock),
    .reset     (reset),
    .write     (write),
    .wen       (wen),
    .read      (w_read),
    .done      (done),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data),
    .out_seq   (w_out_seq),
    .overflow  (w_overflow),
    .drained   (w_drained)
  );
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [63:0] data;
    logic [31:0] seq;
  } entry_t;

  entry_t      mq[$];
  int          m_phase;     // 0 = accepting, 1 = flushing, 2 = finished
  logic [31:0] m_drops;
  logic [31:0] m_wrseq;
  logic        m_ovf;
  logic        m_drained;
  logic [63:0] m_read;
  bit          m_live;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    entry_t e;
    int     sz;
    bit     take;
    bit     acc;
    bit     drp;
    if (reset) begin
      mq.delete();
      m_phase   = 0;
      m_drops   = '0;
      m_wrseq   = '0;
      m_ovf     = 1'b0;
      m_drained = 1'b0;
      m_read    = '0;
    end else begin
      sz   = mq.size();
      take = (sz > 0) && out_ready;
      acc  = (m_phase == 0) && wen && ((sz < DEPTH) || take);
      drp  = (m_phase == 0) && wen && !acc;
      m_read    = {m_drops, 15'd0, (m_phase == 1), 16'(sz)};
      m_drained = (m_phase == 2);
      if (m_phase == 0 && done)      m_phase = 1;
      else if (m_phase == 1 && sz == 0) m_phase = 2;
      if (take) void'(mq.pop_front());
      if (acc) begin
        e.data = write;
        e.seq  = m_wrseq;
        mq.push_back(e);
        m_wrseq++;
      end
      if (drp) begin
        m_ovf = 1'b1;
        if (m_drops != 32'hFFFF_FFFF) m_drops++;
      end
    end
    m_live = 1'b1;
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    if (m_live) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0].data);
        chk("out_seq", 64'(out_seq), SEQ_ON ? 64'(mq[0].seq) : 64'd0);
      end
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drained", 64'(drained), 64'(m_drained));
      chk("read", read, m_read);
`ifdef PROBE_DRAIN_SEQ_EN
      chk("wrap_valid", 64'(w_out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("wrap_data", w_out_data, mq[0].data);
        chk("wrap_seq", 64'(w_out_seq), 64'(mq[0].seq + 32'hFFFF_FFFE));
      end
      chk("wrap_read", w_read, m_read);
`endif
    end
  end

  task automatic step(input logic r, input logic w, input logic [63:0] d,
                      input logic rdy, input logic dn);
    reset     = r;
    wen       = w;
    write     = d;
    out_ready = rdy;
    done      = dn;
    @(posedge clock);
    model_step();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p_rdy;
    int guard;
    checks = 0;
    errors = 0;
    m_live = 1'b0;
    reset = 1'b1; wen = 1'b0; write = '0; out_ready = 1'b0; done = 1'b0;

    // Reset state
    repeat (3) step(1, 0, 0, 0, 0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_seq", 64'(out_seq), 64'd0);
    chk("rst_read", read, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drained", 64'(drained), 64'd0);

    // Single word: one-cycle latency, then level returns to zero
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 64'hDEAD_BEEF_0000_0001, 1, 0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", out_data, 64'hDEAD_BEEF_0000_0001);
    chk("t1_seq", 64'(out_seq), 64'd0);
    step(0, 0, 0, 1, 0);
    chk("t1_popped", 64'(out_valid), 64'd0);
    chk("t1_level_one", 64'(read[15:0]), 64'd1);
    step(0, 0, 0, 1, 0);
    chk("t1_level_zero", 64'(read[15:0]), 64'd0);

    // Fill to 16, overflow on the 17th, then drain in order
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 64'h1000 + 64'(i), 0, 0);
    step(0, 1, 64'h0BAD, 0, 0);
    chk("t2_read_full", read, {32'd0, 15'd0, 1'b0, 16'd16});
    chk("t2_overflow", 64'(overflow), 64'd1);
    step(0, 0, 0, 0, 0);
    chk("t2_read_drop", read, {32'd1, 15'd0, 1'b0, 16'd16});
    for (int i = 0; i < 16; i++) begin
      chk("t2_head_data", out_data, 64'h1000 + 64'(i));
      chk("t2_head_seq", 64'(out_seq), SEQ_ON ? 64'(i) : 64'd0);
      step(0, 0, 0, 1, 0);
    end
    chk("t2_empty", 64'(out_valid), 64'd0);

    // Full FIFO with simultaneous write and read
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 64'h2000 + 64'(i), 0, 0);
    step(0, 1, 64'h2FFF, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t3_read", read, {32'd0, 15'd0, 1'b0, 16'd16});
    chk("t3_no_overflow", 64'(overflow), 64'd0);
    chk("t3_head", out_data, 64'h2001);
    repeat (16) step(0, 0, 0, 1, 0);

    // Reset with words queued
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 64'h3000 + 64'(i), 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_read", read, 64'd0);
    chk("t4_drained", 64'(drained), 64'd0);
    step(0, 1, 64'h3077, 0, 0);
    chk("t4_run_accepts", 64'(out_valid), 64'd1);

    // Flush sequence
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 64'h500 + 64'(i), 0, 0);
    step(0, 1, 64'h505, 0, 1);
    repeat (3) step(0, 1, 64'h5FF, 0, 1);
    chk("t5_read_flush", read, {32'd0, 15'd0, 1'b1, 16'd6});
    for (int i = 0; i < 6; i++) begin
      chk("t5_head", out_data, 64'h500 + 64'(i));
      step(0, 1, 64'h5EE, 1, 0);
    end
    chk("t5_empty", 64'(out_valid), 64'd0);
    chk("t5_not_drained", 64'(drained), 64'd0);
    step(0, 1, 64'h5EE, 1, 0);
    chk("t5_enter_done", 64'(drained), 64'd0);
    step(0, 1, 64'h5EE, 1, 0);
    chk("t5_drained", 64'(drained), 64'd1);
    step(0, 1, 64'h5EE, 1, 0);
    chk("t5_done_ignores", 64'(out_valid), 64'd0);

    // Random traffic
    step(1, 0, 0, 0, 0);
    p_rdy = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(2, 0))
          0:       p_rdy = 15;
          1:       p_rdy = 50;
          default: p_rdy = 90;
        endcase
      end
      step(0, ($urandom_range(99, 0) < 70), {$urandom, $urandom},
           ($urandom_range(99, 0) < p_rdy), 0);
    end
    chk("rand_overflow_seen", 64'(overflow), 64'd1);
    guard = 0;
    while (!drained && guard < 100) begin
      step(0, 1'($urandom_range(1, 0)), {$urandom, $urandom}, 1, 1);
      guard++;
    end
    chk("rand_drained", 64'(drained), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
